// File: rtl/dbg_mem_loader.sv
// Byte-stream debug loader: owns the debug memory port and CPU reset line.
// Loads and reads memory over a UART byte pipe while the CPU is held.
module dbg_mem_loader #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int TIMEOUT   = 100000,
    parameter int BOOT_HOLD = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                cpu_n_reset,
    output logic                dbg_mem_op,
    output logic [DATA_W/8-1:0] dbg_wren,
    output logic [ADDR_W-1:0]   dbg_adr,
    output logic [DATA_W-1:0]   dbg_do,
    input  logic [DATA_W-1:0]   dbg_di,
    input  logic                dbg_ack
);

    localparam int BPW = DATA_W / 8;
    localparam int AB  = ADDR_W / 8;
    localparam int LB  = LEN_W / 8;
    localparam int TW  = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_LEN   = 3'd2;
    localparam logic [2:0] S_WDATA = 3'd3;
    localparam logic [2:0] S_WBUS  = 3'd4;
    localparam logic [2:0] S_RBUS  = 3'd5;
    localparam logic [2:0] S_RSEND = 3'd6;
    localparam logic [2:0] S_RESP  = 3'd7;

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    logic [2:0]        state_q, state_d;
    logic              wr_q, wr_d;
    logic              cpu_q, cpu_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [7:0]        bcnt_q, bcnt_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [7:0]        txd_q, txd_d;
    logic              txv_q, txv_d;
    logic              op_q, op_d;
    logic [BPW-1:0]    wren_q, wren_d;

    logic              rx_fire;
    logic              ack_fire;
    logic              tmo_hit;
    logic [ADDR_W-1:0] adr_sh;
    logic [LEN_W-1:0]  cnt_sh;
    logic [DATA_W-1:0] word_sh;

    assign rx_ready = (state_q == S_IDLE) || (state_q == S_ADDR) ||
                      (state_q == S_LEN) || (state_q == S_WDATA);
    assign rx_fire  = rx_valid && rx_ready;
    assign ack_fire = op_q && dbg_ack;
    assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));

    // Multi-byte fields arrive LE: shift each byte in from the top.
    assign adr_sh  = (adr_q >> 8) | (ADDR_W'(rx_data) << (ADDR_W - 8));
    assign cnt_sh  = (cnt_q >> 8) | (LEN_W'(rx_data) << (LEN_W - 8));
    assign word_sh = (word_q >> 8) | (DATA_W'(rx_data) << (DATA_W - 8));

    assign tx_data     = txd_q;
    assign tx_valid    = txv_q;
    assign cpu_n_reset = cpu_q;
    assign dbg_mem_op  = op_q;
    assign dbg_wren    = wren_q;
    assign dbg_adr     = adr_q;
    assign dbg_do      = word_q;

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        cpu_d   = cpu_q;
        adr_d   = adr_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        bcnt_d  = bcnt_q;
        txd_d   = txd_q;
        txv_d   = txv_q;
        op_d    = op_q;
        wren_d  = wren_q;
        tmo_d   = '0;
        if (rx_ready && !rx_valid && state_q != S_IDLE) begin
            tmo_d = tmo_q + TW'(1);
        end
        unique case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    bcnt_d  = '0;
                    state_d = S_RESP;
                    txv_d   = 1'b1;
                    txd_d   = NAK;
                    case (rx_data)
                        8'h57, 8'h52: begin
                            if (!cpu_q) begin
                                state_d = S_ADDR;
                                txv_d   = 1'b0;
                                wr_d    = (rx_data == 8'h57);
                            end
                        end
                        8'h47: begin
                            cpu_d = 1'b1;
                            txd_d = ACK;
                        end
                        8'h48: begin
                            cpu_d = 1'b0;
                            txd_d = ACK;
                        end
                        default: ;
                    endcase
                end
            end
            S_ADDR: begin
                if (rx_fire) begin
                    adr_d  = adr_sh;
                    bcnt_d = bcnt_q + 8'd1;
                    if (bcnt_q == 8'(AB - 1)) begin
                        bcnt_d  = '0;
                        state_d = S_LEN;
                    end
                end else if (tmo_hit) begin
                    txv_d   = 1'b1;
                    txd_d   = NAK;
                    state_d = S_RESP;
                end
            end
            S_LEN: begin
                if (rx_fire) begin
                    cnt_d  = cnt_sh;
                    bcnt_d = bcnt_q + 8'd1;
                    if (bcnt_q == 8'(LB - 1)) begin
                        bcnt_d = '0;
                        if (cnt_sh == '0) begin
                            txv_d   = 1'b1;
                            txd_d   = ACK;
                            state_d = S_RESP;
                        end else if (wr_q) begin
                            state_d = S_WDATA;
                        end else begin
                            op_d    = 1'b1;
                            state_d = S_RBUS;
                        end
                    end
                end else if (tmo_hit) begin
                    txv_d   = 1'b1;
                    txd_d   = NAK;
                    state_d = S_RESP;
                end
            end
            S_WDATA: begin
                if (rx_fire) begin
                    word_d = word_sh;
                    bcnt_d = bcnt_q + 8'd1;
                    if (bcnt_q == 8'(BPW - 1)) begin
                        bcnt_d  = '0;
                        op_d    = 1'b1;
                        wren_d  = '1;
                        state_d = S_WBUS;
                    end
                end else if (tmo_hit) begin
                    txv_d   = 1'b1;
                    txd_d   = NAK;
                    state_d = S_RESP;
                end
            end
            S_WBUS: begin
                if (ack_fire) begin
                    op_d   = 1'b0;
                    wren_d = '0;
                    adr_d  = adr_q + ADDR_W'(BPW);
                    cnt_d  = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        txv_d   = 1'b1;
                        txd_d   = ACK;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WDATA;
                    end
                end
            end
            S_RBUS: begin
                if (ack_fire) begin
                    op_d    = 1'b0;
                    word_d  = dbg_di;
                    adr_d   = adr_q + ADDR_W'(BPW);
                    cnt_d   = cnt_q - LEN_W'(1);
                    bcnt_d  = '0;
                    state_d = S_RSEND;
                end
            end
            S_RSEND: begin
                if (!txv_q) begin
                    txv_d = 1'b1;
                    txd_d = word_q[7:0];
                end else if (tx_ready) begin
                    txv_d  = 1'b0;
                    word_d = word_q >> 8;
                    bcnt_d = bcnt_q + 8'd1;
                    if (bcnt_q == 8'(BPW - 1)) begin
                        bcnt_d = '0;
                        if (cnt_q == '0) begin
                            state_d = S_RESP;
                        end else begin
                            op_d    = 1'b1;
                            state_d = S_RBUS;
                        end
                    end
                end
            end
            S_RESP: begin
                // Entered with the byte already loaded, except after a read burst.
                if (!txv_q) begin
                    txv_d = 1'b1;
                    txd_d = ACK;
                end else if (tx_ready) begin
                    txv_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            cpu_q   <= (BOOT_HOLD == 0);
            adr_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            bcnt_q  <= '0;
            tmo_q   <= '0;
            txd_q   <= '0;
            txv_q   <= 1'b0;
            op_q    <= 1'b0;
            wren_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            cpu_q   <= cpu_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            bcnt_q  <= bcnt_d;
            tmo_q   <= tmo_d;
            txd_q   <= txd_d;
            txv_q   <= txv_d;
            op_q    <= op_d;
            wren_q  <= wren_d;
        end
    end

endmodule

// File: tb/tb_dbg_mem_loader.sv
// Scoreboard bench for dbg_mem_loader: bus responder with a
// delayed ack, a tx sink with optional backpressure, byte-level stimulus.
module tb_dbg_mem_loader;
    localparam int TMO = 200;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } bus_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        cpu_n_reset;
    logic        dbg_mem_op;
    logic [3:0]  dbg_wren;
    logic [31:0] dbg_adr;
    logic [31:0] dbg_do;
    logic [31:0] dbg_di;
    logic        dbg_ack;

    dbg_mem_loader #(
        .ADDR_W(32), .DATA_W(32), .LEN_W(16),
        .TIMEOUT(TMO), .BOOT_HOLD(1)
    ) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .cpu_n_reset(cpu_n_reset), .dbg_mem_op(dbg_mem_op),
        .dbg_wren(dbg_wren), .dbg_adr(dbg_adr), .dbg_do(dbg_do),
        .dbg_di(dbg_di), .dbg_ack(dbg_ack)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    bus_t        exp_bus[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] model[bit [31:0]];
    logic [31:0] bmem[bit [31:0]];
    logic [31:0] wbuf[4];
    int          ack_dly = 3;
    bit          tx_rand = 1'b0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mrd(input logic [31:0] a);
        return model.exists(a) ? model[a] : 32'h0;
    endfunction

    // Bus responder: ack after ack_dly waiting cycles, checks each access.
    initial begin
        int w = 0;
        logic [31:0] a0 = '0;
        bus_t e;
        dbg_ack = 1'b0;
        dbg_di  = '0;
        forever begin
            @(negedge clk);
            dbg_ack = 1'b0;
            if (dbg_mem_op && !reset) begin
                if (w == 0) a0 = dbg_adr;
                if (w >= ack_dly) begin
                    w = 0;
                    check("bus_hold_adr", dbg_adr, a0);
                    if (exp_bus.size() == 0) begin
                        check("bus_extra", exp_bus.size(), 1);
                    end else begin
                        e = exp_bus.pop_front();
                        check("bus_wren", dbg_wren, e.we ? 4'hF : 4'h0);
                        check("bus_adr", dbg_adr, e.adr);
                        if (e.we) check("bus_wdata", dbg_do, e.dat);
                    end
                    if (dbg_wren != 4'h0) bmem[dbg_adr] = dbg_do;
                    else dbg_di = bmem.exists(dbg_adr) ? bmem[dbg_adr] : 32'h0;
                    dbg_ack = 1'b1;
                end else begin
                    w++;
                end
            end else begin
                w = 0;
            end
        end
    end

    // Tx sink: handshake decided here completes at the next posedge.
    initial begin
        logic [7:0] e;
        tx_ready = 1'b0;
        forever begin
            @(negedge clk);
            tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tx_valid && tx_ready && !reset) begin
                if (exp_tx.size() == 0) begin
                    check("tx_extra", exp_tx.size(), 1);
                end else begin
                    e = exp_tx.pop_front();
                    check("tx_byte", tx_data, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int k = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (!rx_ready) check("rx_stall", k, 0);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_ac(input logic [31:0] a, input logic [15:0] n);
        for (int i = 0; i < 4; i++) send(a[8*i +: 8]);
        send(n[7:0]);
        send(n[15:8]);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while ((exp_tx.size() != 0 || exp_bus.size() != 0) && k < 3000) begin
            tick(1);
            k++;
        end
        check({tag, "_done"}, exp_tx.size() + exp_bus.size(), 0);
        tick(2);
    endtask

    task automatic do_write(input logic [31:0] a, input int n);
        logic [31:0] p = a;
        for (int i = 0; i < n; i++) begin
            exp_bus.push_back('{we: 1'b1, adr: p, dat: wbuf[i]});
            model[p] = wbuf[i];
            p += 32'd4;
        end
        exp_tx.push_back(8'h06);
        send(8'h57);
        send_ac(a, 16'(n));
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 4; b++) send(wbuf[i][8*b +: 8]);
        wait_done("write");
    endtask

    task automatic do_read(input logic [31:0] a, input int n);
        logic [31:0] p = a;
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            d = mrd(p);
            exp_bus.push_back('{we: 1'b0, adr: p, dat: d});
            for (int b = 0; b < 4; b++) exp_tx.push_back(d[8*b +: 8]);
            p += 32'd4;
        end
        exp_tx.push_back(8'h06);
        send(8'h52);
        send_ac(a, 16'(n));
        wait_done("read");
    endtask

    task automatic do_cmd(input logic [7:0] c, input logic [7:0] r);
        exp_tx.push_back(r);
        send(c);
        wait_done("cmd");
    endtask

    initial begin
        int k;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_cpu_n_reset", cpu_n_reset, 1'b0);
        check("rst_mem_op", dbg_mem_op, 1'b0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_rx_ready", rx_ready, 1'b1);
        check("rst_wren", dbg_wren, 4'h0);

        wbuf[0] = 32'h0000_00AA;
        do_write(32'h0000_0000, 1);
        wbuf[0] = 32'h0000_00BB;
        do_write(32'h0001_0000, 1);
        wbuf[0] = 32'h0000_00CC;
        do_write(32'h0002_0020, 1);

        wbuf[0] = 32'h1122_3344;
        wbuf[1] = 32'h5566_7788;
        do_write(32'h0002_0000, 2);
        tx_rand = 1'b1;
        do_read(32'h0002_0000, 2);
        do_read(32'h0002_0020, 1);
        tx_rand = 1'b0;

        wbuf[0] = 32'hDEAD_BEEF;
        wbuf[1] = 32'h0BAD_F00D;
        do_write(32'hFFFF_FFFC, 2);
        do_read(32'hFFFF_FFFC, 2);
        do_write(32'h0000_0100, 0);
        do_read(32'h0000_0100, 0);

        do_cmd(8'h47, 8'h06);
        check("go_cpu_n_reset", cpu_n_reset, 1'b1);
        do_cmd(8'h57, 8'h15);
        check("guard_rx_ready", rx_ready, 1'b1);
        do_cmd(8'h52, 8'h15);
        do_cmd(8'h48, 8'h06);
        check("halt_cpu_n_reset", cpu_n_reset, 1'b0);
        do_cmd(8'h7A, 8'h15);

        exp_tx.push_back(8'h15);
        send(8'h57);
        send(8'h00);
        send(8'h00);
        wait_done("timeout");
        check("tmo_rx_ready", rx_ready, 1'b1);
        do_read(32'h0000_0000, 1);

        ack_dly = 20;
        send(8'h52);
        send_ac(32'h0002_0000, 16'd2);
        k = 0;
        while (!dbg_mem_op && k < 100) begin
            tick(1);
            k++;
        end
        check("abort_bus_started", dbg_mem_op, 1'b1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("abort_mem_op", dbg_mem_op, 1'b0);
        check("abort_tx_valid", tx_valid, 1'b0);
        check("abort_wren", dbg_wren, 4'h0);
        check("abort_adr", dbg_adr, 32'h0);
        check("abort_cpu_n_reset", cpu_n_reset, 1'b0);
        check("abort_rx_ready", rx_ready, 1'b1);
        ack_dly = 3;
        tick(60);
        do_cmd(8'h48, 8'h06);

        check("tx_left", exp_tx.size(), 0);
        check("bus_left", exp_bus.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
